// File: rtl/mem_stage_pkg.sv
// Purpose : shared widths, stall/load-op encodings and bus payload types for the MEM stage.
// Contents: bus widths, STOP/NO_STOP levels, LD_* load-op codes, ex_mem_t / mem_id_t / mem_wb_t.
package mem_stage_pkg;

    localparam int unsigned DATA_W       = 32;
    localparam int unsigned STALL_W      = 6;
    localparam int unsigned DEF_LD_OP_W  = 3;
    localparam int unsigned EX_TO_MEM_WD = 79;
    localparam int unsigned EX_LOW_WD    = 76;   // ex_to_mem_bus below the ld_op field
    localparam int unsigned MEM_TO_WB_WD = 70;
    localparam int unsigned MEM_TO_ID_WD = 38;

    localparam logic STOP    = 1'b1;
    localparam logic NO_STOP = 1'b0;

    localparam int unsigned LD_LW  = 0;
    localparam int unsigned LD_LB  = 1;
    localparam int unsigned LD_LBU = 2;
    localparam int unsigned LD_LH  = 3;
    localparam int unsigned LD_LHU = 4;

    // ex_to_mem_bus[75:0]
    typedef struct packed {
        logic [31:0] pc;
        logic        ram_en;
        logic [3:0]  ram_wen;
        logic        sel_rf_res;
        logic        rf_we;
        logic [4:0]  rf_waddr;
        logic [31:0] ex_result;
    } ex_mem_t;

    // mem_to_id_bus, also the low 38 bits of mem_to_wb_bus
    typedef struct packed {
        logic        rf_we;
        logic [4:0]  rf_waddr;
        logic [31:0] rf_wdata;
    } mem_id_t;

    typedef struct packed {
        logic [31:0] pc;
        mem_id_t     fwd;
    } mem_wb_t;

endpackage

// File: rtl/mem_load_align.sv
// Purpose : combinational load alignment and sign/zero extension (little-endian lanes).
// Ports   : ld_word (raw 32-bit word), addr (byte offset), ld_op (load type) -> ld_ext.
// Config  : only built when MEM_SUBWORD_LOAD_EN is defined.
`ifdef MEM_SUBWORD_LOAD_EN
module mem_load_align
    import mem_stage_pkg::*;
#(
    parameter int unsigned LD_OP_W = DEF_LD_OP_W
) (
    input  logic [DATA_W-1:0]  ld_word,
    input  logic [1:0]         addr,
    input  logic [LD_OP_W-1:0] ld_op,
    output logic [DATA_W-1:0]  ld_ext
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Misaligned halves use addr[1] only; unknown ops fall back to a word load.
    always_comb begin
        byte_sel = ld_word[{addr, 3'b000} +: 8];
        half_sel = addr[1] ? ld_word[31:16] : ld_word[15:0];
        ld_ext   = ld_word;
        case (ld_op)
            LD_OP_W'(LD_LB):  ld_ext = {{24{byte_sel[7]}}, byte_sel};
            LD_OP_W'(LD_LBU): ld_ext = {24'b0, byte_sel};
            LD_OP_W'(LD_LH):  ld_ext = {{16{half_sel[15]}}, half_sel};
            LD_OP_W'(LD_LHU): ld_ext = {16'b0, half_sel};
            default:          ld_ext = ld_word;
        endcase
    end

endmodule
`endif

// File: rtl/mem_stage.sv
// Purpose : MEM pipeline stage. Registers the EX bus, keeps SRAM read data alive across
//           stalls, aligns/extends loads and selects the write-back value.
// Ports   : clk, rst (sync, active-high), stall (stall vector, bits 3 and 4 used),
//           ex_to_mem_bus, data_sram_rdata -> mem_to_wb_bus, mem_to_id_bus (forwarding).
// Config  : MEM_SUBWORD_LOAD_EN enables LB/LBU/LH/LHU; otherwise every load returns the raw word.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int unsigned LD_OP_W = DEF_LD_OP_W,
    parameter logic [31:0] RST_PC  = 32'h0
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [STALL_W-1:0]             stall,
    input  logic [EX_LOW_WD+LD_OP_W-1:0]   ex_to_mem_bus,
    input  logic [DATA_W-1:0]              data_sram_rdata,
    output logic [MEM_TO_WB_WD-1:0]        mem_to_wb_bus,
    output logic [MEM_TO_ID_WD-1:0]        mem_to_id_bus
);

    ex_mem_t             in_fields;
    ex_mem_t             bus_r;
    ex_mem_t             bubble;
    logic [LD_OP_W-1:0]  in_ld_op;
    logic [LD_OP_W-1:0]  ld_op_r;
    logic                hold_v;
    logic [DATA_W-1:0]   hold_d;
    logic                bubble_req;
    logic                load_req;
    logic                capture;
    logic [DATA_W-1:0]   ld_word;
    logic [DATA_W-1:0]   ld_ext;
    logic [DATA_W-1:0]   rf_wdata;
    mem_id_t             fwd;
    logic                unused_stall;

    assign in_fields    = ex_mem_t'(ex_to_mem_bus[EX_LOW_WD-1:0]);
    assign in_ld_op     = ex_to_mem_bus[EX_LOW_WD +: LD_OP_W];
    assign bubble       = ex_mem_t'({RST_PC, 44'b0});
    assign unused_stall = ^{stall[STALL_W-1:5], stall[2:0]};

    assign bubble_req = (stall[3] == STOP) && (stall[4] == NO_STOP);
    assign load_req   = (stall[3] == NO_STOP);
    // A load stalled in MEM keeps the first rdata it sees; later rdata may be garbage.
    assign capture    = !hold_v && (stall[3] == STOP) && bus_r.ram_en && (bus_r.ram_wen == 4'b0);

    // Stage register and rdata hold; reset and bubble clear both in the same edge.
    always_ff @(posedge clk) begin
        if (rst || bubble_req) begin
            bus_r   <= bubble;
            ld_op_r <= '0;
            hold_v  <= 1'b0;
            hold_d  <= '0;
        end else if (load_req) begin
            bus_r   <= in_fields;
            ld_op_r <= in_ld_op;
            hold_v  <= 1'b0;
        end else if (capture) begin
            hold_v  <= 1'b1;
            hold_d  <= data_sram_rdata;
        end
    end

    assign ld_word = hold_v ? hold_d : data_sram_rdata;

`ifdef MEM_SUBWORD_LOAD_EN
    mem_load_align #(
        .LD_OP_W (LD_OP_W)
    ) u_align (
        .ld_word (ld_word),
        .addr    (bus_r.ex_result[1:0]),
        .ld_op   (ld_op_r),
        .ld_ext  (ld_ext)
    );
`else
    logic unused_ld_op;
    assign unused_ld_op = ^ld_op_r;
    assign ld_ext       = ld_word;
`endif

    // Write-back select and output packing.
    assign rf_wdata      = bus_r.sel_rf_res ? ld_ext : bus_r.ex_result;
    assign fwd           = {bus_r.rf_we, bus_r.rf_waddr, rf_wdata};
    assign mem_to_id_bus = fwd;
    assign mem_to_wb_bus = {bus_r.pc, fwd};

endmodule

// File: tb/tb_mem_stage.sv
// Purpose : self-checking bench for mem_stage: directed cases with literal expectations
//           followed by randomized traffic compared every cycle against a behavioural model.
// Config  : expectations follow MEM_SUBWORD_LOAD_EN the same way the design does.
module tb_mem_stage;

    logic        clk;
    logic        rst;
    logic [5:0]  stall;
    logic [78:0] ex_bus;
    logic [31:0] rdata;
    logic [69:0] mem_to_wb_bus;
    logic [37:0] mem_to_id_bus;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    // Model of the stage contents
    logic [78:0] m_bus = '0;
    bit          m_hv  = 1'b0;
    logic [31:0] m_hd  = '0;

    localparam logic [5:0] ST_RUN    = 6'b000000;
    localparam logic [5:0] ST_HOLD   = 6'b011000;
    localparam logic [5:0] ST_BUBBLE = 6'b001000;

    mem_stage dut (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall),
        .ex_to_mem_bus   (ex_bus),
        .data_sram_rdata (rdata),
        .mem_to_wb_bus   (mem_to_wb_bus),
        .mem_to_id_bus   (mem_to_id_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [78:0] mk_bus(input logic [2:0] op, input logic [31:0] pc,
                                           input logic ram_en, input logic [3:0] wen,
                                           input logic sel, input logic we,
                                           input logic [4:0] waddr, input logic [31:0] ex);
        return {op, pc, ram_en, wen, sel, we, waddr, ex};
    endfunction

    // Expected load value from the word, byte offset and load type.
    function automatic logic [31:0] ref_ext(input logic [31:0] w, input logic [1:0] a,
                                            input logic [2:0] op);
`ifdef MEM_SUBWORD_LOAD_EN
        logic [31:0] b;
        logic [31:0] h;
        b = (w >> (8 * a)) & 32'hFF;
        h = (w >> (a[1] ? 16 : 0)) & 32'hFFFF;
        case (op)
            3'd1:    return (b >= 32'h80) ? (b | 32'hFFFF_FF00) : b;
            3'd2:    return b;
            3'd3:    return (h >= 32'h8000) ? (h | 32'hFFFF_0000) : h;
            3'd4:    return h;
            default: return w;
        endcase
`else
        if (op == 3'd7 && a == 2'd3) return w;
        return w;
`endif
    endfunction

    function automatic logic [69:0] model_wb();
        logic [31:0] word;
        logic [31:0] wdata;
        word  = m_hv ? m_hd : rdata;
        wdata = m_bus[38] ? ref_ext(word, m_bus[1:0], m_bus[78:76]) : m_bus[31:0];
        return {m_bus[75:44], m_bus[37], m_bus[36:32], wdata};
    endfunction

    task automatic check(input string name, input logic [69:0] act, input logic [69:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance the model by one clock edge using the inputs present at that edge.
    task automatic model_update();
        if (rst) begin
            m_bus = '0;
            m_hv  = 1'b0;
        end else if (stall[3] && !stall[4]) begin
            m_bus = '0;
            m_hv  = 1'b0;
        end else if (!stall[3]) begin
            m_bus = ex_bus;
            m_hv  = 1'b0;
        end else if (!m_hv && m_bus[43] && m_bus[42:39] == 4'b0) begin
            m_hv  = 1'b1;
            m_hd  = rdata;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic drive(input logic r, input logic [5:0] s, input logic [78:0] b,
                         input logic [31:0] d);
        rst    = r;
        stall  = s;
        ex_bus = b;
        rdata  = d;
    endtask

    // Put a load in MEM, present rdata, and check the write-back word against a literal.
    task automatic load_check(input string name, input logic [2:0] op, input logic [1:0] a,
                              input logic [31:0] d, input logic [31:0] exp);
        drive(1'b0, ST_RUN, mk_bus(op, 32'h100, 1'b1, 4'h0, 1'b1, 1'b1, 5'd3, {30'h400, a}), 32'h0);
        tick();
        drive(1'b0, ST_RUN, '0, d);
        @(negedge clk);
        check(name, {38'b0, mem_to_wb_bus[31:0]}, {38'b0, exp});
        tick();
    endtask

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            check("wb_bus", mem_to_wb_bus, model_wb());
            check("id_bus", {32'b0, mem_to_id_bus}, {32'b0, model_wb()[37:0]});
        end
    end

    initial begin
        logic [31:0] w3;
        w3 = 32'h80FF_7F01;
        drive(1'b1, ST_RUN, '0, 32'h0);

        // Reset
        tick();
        chk_en = 1'b1;
        tick();
        drive(1'b0, ST_RUN, '0, 32'h0);
        @(negedge clk);
        check("rst_wb", mem_to_wb_bus, 70'b0);
        check("rst_id_we", {69'b0, mem_to_id_bus[37]}, 70'b0);
        tick();

        // ALU pass-through
        drive(1'b0, ST_RUN, mk_bus(3'd0, 32'h40, 1'b0, 4'h0, 1'b0, 1'b1, 5'd5, 32'h1234_5678), 32'h0);
        tick();
        drive(1'b0, ST_RUN, '0, 32'hFFFF_FFFF);
        @(negedge clk);
        check("alu_wb_data", {38'b0, mem_to_wb_bus[31:0]}, {38'b0, 32'h1234_5678});
        check("alu_wb_addr", {65'b0, mem_to_wb_bus[36:32]}, 70'd5);
        check("alu_id_data", {38'b0, mem_to_id_bus[31:0]}, {38'b0, 32'h1234_5678});
        check("alu_id_addr", {65'b0, mem_to_id_bus[36:32]}, 70'd5);
        tick();

        // Sub-word loads
`ifdef MEM_SUBWORD_LOAD_EN
        load_check("lb_a3",  3'd1, 2'd3, 32'h80FF_7F01, 32'hFFFF_FF80);
        load_check("lbu_a3", 3'd2, 2'd3, 32'h80FF_7F01, 32'h0000_0080);
        load_check("lb_a1",  3'd1, 2'd1, 32'h80FF_7F01, 32'h0000_007F);
        load_check("lh_a2",  3'd3, 2'd2, 32'h8001_7FFE, 32'hFFFF_8001);
        load_check("lhu_a2", 3'd4, 2'd2, 32'h8001_7FFE, 32'h0000_8001);
        load_check("lh_a0",  3'd3, 2'd0, 32'h8001_7FFE, 32'h0000_7FFE);
`else
        load_check("lb_a3_raw",  3'd1, 2'd3, w3, 32'h80FF_7F01);
        load_check("lbu_a3_raw", 3'd2, 2'd3, w3, 32'h80FF_7F01);
        load_check("lb_a1_raw",  3'd1, 2'd1, w3, 32'h80FF_7F01);
        load_check("lh_a2_raw",  3'd3, 2'd2, 32'h8001_7FFE, 32'h8001_7FFE);
`endif

        // Stalled LW keeps the first rdata
        drive(1'b0, ST_RUN, mk_bus(3'd0, 32'h200, 1'b1, 4'h0, 1'b1, 1'b1, 5'd7, 32'h2000), 32'h0);
        tick();
        drive(1'b0, ST_HOLD, '0, 32'hDEAD_BEEF);
        @(negedge clk);
        check("stall_c1", {38'b0, mem_to_wb_bus[31:0]}, {38'b0, 32'hDEAD_BEEF});
        tick();
        drive(1'b0, ST_HOLD, '0, 32'h0);
        @(negedge clk);
        check("stall_c2", {38'b0, mem_to_wb_bus[31:0]}, {38'b0, 32'hDEAD_BEEF});
        tick();
        @(negedge clk);
        check("stall_c3", {38'b0, mem_to_wb_bus[31:0]}, {38'b0, 32'hDEAD_BEEF});
        tick();
        drive(1'b0, ST_RUN, '0, 32'h0);
        @(negedge clk);
        check("stall_release", {38'b0, mem_to_id_bus[31:0]}, {38'b0, 32'hDEAD_BEEF});
        tick();

        // Bubble insertion
        drive(1'b0, ST_RUN, mk_bus(3'd0, 32'h300, 1'b0, 4'h0, 1'b0, 1'b1, 5'd9, 32'hABCD), 32'h0);
        tick();
        drive(1'b0, ST_BUBBLE, mk_bus(3'd0, 32'h304, 1'b0, 4'h0, 1'b0, 1'b1, 5'd10, 32'h1), 32'h55);
        tick();
        drive(1'b0, ST_HOLD, '0, 32'h0);
        @(negedge clk);
        check("bubble_wb", mem_to_wb_bus, 70'b0);
        check("bubble_id_we", {69'b0, mem_to_id_bus[37]}, 70'b0);
        tick();

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            logic [5:0]  s;
            logic [78:0] b;
            int unsigned pick;
            pick = $urandom_range(0, 9);
            if (pick < 4)      s = ST_RUN;
            else if (pick < 7) s = ST_HOLD;
            else if (pick < 8) s = ST_BUBBLE;
            else               s = 6'($urandom);
            b = mk_bus(3'($urandom_range(0, 7)), $urandom, 1'($urandom),
                       ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom),
                       1'($urandom), 1'($urandom), 5'($urandom), $urandom);
            drive(($urandom_range(0, 49) == 0), s, b, $urandom);
            tick();
        end

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
